// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Fixed 33-cycle latency: 32 shift-add or restoring-divide steps plus one sign-fix cycle.
`timescale 1ns/1ps
module ex_muldiv_unit (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] OperandA,
   input  logic [31:0] OperandB,
   input  logic        HiWrite,
   input  logic        LoWrite,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic        is_div;
   logic        neg_lo;      // product / quotient sign
   logic        neg_hi;      // remainder sign
   logic        b_zero;
   logic [31:0] operand_b;
   logic [63:0] acc;         // {upper/remainder, lower/multiplier-or-quotient}

   logic        op_signed, a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [31:0] div_sub;
   logic        div_restore;
   logic [63:0] acc_next;
   logic [63:0] prod_res;
   logic [31:0] hi_res, lo_res;

   always_comb begin
      op_signed = ~Op[0];
      a_neg     = op_signed & OperandA[31];
      b_neg     = op_signed & OperandB[31];
      a_abs     = a_neg ? (~OperandA + 32'd1) : OperandA;
      b_abs     = b_neg ? (~OperandB + 32'd1) : OperandB;
   end

   // Both algorithms share one 64-bit register: the low half shifts out multiplier
   // bits (multiply) or shifts dividend bits into the remainder (divide).
   always_comb begin
      mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand_b} : 33'd0);
      div_shift   = {acc[63:32], acc[31]};
      div_restore = div_shift < {1'b0, operand_b};
      div_sub     = div_shift[31:0] - operand_b;
      if (is_div) begin
         acc_next = div_restore ? {div_shift[31:0], acc[30:0], 1'b0}
                                : {div_sub, acc[30:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[31:1]};
      end
   end

   always_comb begin
      prod_res = neg_lo ? (~acc + 64'd1) : acc;
      if (is_div) begin
         lo_res = b_zero ? '1 : (neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0]);
         hi_res = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
      end else begin
         lo_res = prod_res[31:0];
         hi_res = prod_res[63:32];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = CALC;
         CALC:    if (count == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count     <= '0;
         is_div    <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         b_zero    <= 1'b0;
         operand_b <= '0;
         acc       <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         case (state)
            IDLE: begin
               if (HiWrite) Hi <= WriteData;
               if (LoWrite) Lo <= WriteData;
               if (Start) begin
                  is_div    <= Op[1];
                  neg_lo    <= a_neg ^ b_neg;
                  neg_hi    <= Op[1] & a_neg;
                  b_zero    <= (OperandB == 32'd0);
                  operand_b <= b_abs;
                  acc       <= {32'd0, a_abs};
                  count     <= '0;
                  Busy      <= 1'b1;
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + 5'd1;
            end
            FIX: begin
               Hi        <= hi_res;
               Lo        <= lo_res;
               Busy      <= 1'b0;
               Done      <= 1'b1;
               DivByZero <= is_div & b_zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed results, latency, Start/MTHI
// masking while busy, back-to-back issue and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

   logic        Clk;
   logic        Reset_n;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] OperandA;
   logic [31:0] OperandB;
   logic        HiWrite;
   logic        LoWrite;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int n_cmp = 0;
   int n_err = 0;

   ex_muldiv_unit dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .HiWrite   (HiWrite),
      .LoWrite   (LoWrite),
      .WriteData (WriteData),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; issues Start there and returns at the negedge where Done
   // should be high. A nonzero disturb index pulses Start/MTHI/MTLO on that busy cycle.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz, input int disturb);
      int cnt;
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(negedge Clk);
      Start    = 1'b0;
      Op       = ~op;
      OperandA = 32'h1357_9BDF;
      OperandB = 32'h0000_0003;
      cnt = 0;
      while (Busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == disturb) begin
            Start     = 1'b1;
            Op        = 2'b11;
            OperandA  = 32'h0000_0064;
            OperandB  = 32'h0000_0003;
            HiWrite   = 1'b1;
            LoWrite   = 1'b1;
            WriteData = 32'hDEAD_BEEF;
         end else begin
            Start   = 1'b0;
            HiWrite = 1'b0;
            LoWrite = 1'b0;
         end
         @(negedge Clk);
      end
      Start   = 1'b0;
      HiWrite = 1'b0;
      LoWrite = 1'b0;
      check({tag, "_busy_cycles"}, cnt, 32'd33);
      check({tag, "_done"}, {31'd0, Done}, 32'd1);
      check({tag, "_hi"}, Hi, exp_hi);
      check({tag, "_lo"}, Lo, exp_lo);
      check({tag, "_dz"}, {31'd0, DivByZero}, {31'd0, exp_dz});
   endtask

   initial begin
      logic done_seen;
      logic busy_seen;

      Reset_n   = 1'b0;
      Start     = 1'b0;
      Op        = 2'b00;
      OperandA  = '0;
      OperandB  = '0;
      HiWrite   = 1'b0;
      LoWrite   = 1'b0;
      WriteData = '0;

      #1;
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_dz", {31'd0, DivByZero}, 32'd0);
      check("rst_hi", Hi, 32'd0);
      check("rst_lo", Lo, 32'd0);

      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
      @(negedge Clk);
      check("multu_done_pulse", {31'd0, Done}, 32'd0);

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
      @(negedge Clk);

      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
      @(negedge Clk);
      check("dz_clears", {31'd0, DivByZero}, 32'd0);

      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
      @(negedge Clk);

      run_op("start_ignored", 2'b01, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0, 10);
      run_op("b2b_mult", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
      run_op("b2b_div", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("div_zero_s", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
      @(negedge Clk);

      // Asynchronous reset at busy cycle 15 of a divide, between clock edges.
      Start    = 1'b1;
      Op       = 2'b10;
      OperandA = 32'd100;
      OperandB = 32'd7;
      @(negedge Clk);
      Start = 1'b0;
      repeat (14) @(negedge Clk);
      check("pre_rst_busy", {31'd0, Busy}, 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      check("mid_rst_done", {31'd0, Done}, 32'd0);
      check("mid_rst_hi", Hi, 32'd0);
      check("mid_rst_lo", Lo, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      done_seen = 1'b0;
      busy_seen = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         done_seen = done_seen | Done;
         busy_seen = busy_seen | Busy;
      end
      check("abandon_no_done", {31'd0, done_seen}, 32'd0);
      check("abandon_no_busy", {31'd0, busy_seen}, 32'd0);

      LoWrite   = 1'b1;
      WriteData = 32'h0000_1234;
      @(negedge Clk);
      LoWrite = 1'b0;
      check("mtlo_lo", Lo, 32'h0000_1234);
      check("mtlo_hi", Hi, 32'd0);

      HiWrite   = 1'b1;
      WriteData = 32'h0000_CAFE;
      @(negedge Clk);
      HiWrite = 1'b0;
      check("mthi_hi", Hi, 32'h0000_CAFE);

      // MTHI coinciding with Start lands, then FIX overwrites it.
      HiWrite   = 1'b1;
      WriteData = 32'h5555_5555;
      run_op("fresh_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
